// File: rtl/fetch_unit_pkg.sv
// Shared pipeline types for the fetch stage and its consumers (decode).
// Holds the F/D register layout, the fetch FSM encoding and bus widths.
package fetch_unit_pkg;

  localparam int IBUS_ADDR_W = 64;
  localparam int IBUS_DATA_W = 32;
  localparam logic [IBUS_ADDR_W-1:0] PC_RESET = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic                   valid;
    logic [IBUS_DATA_W-1:0] instr;
    logic [IBUS_ADDR_W-1:0] pc;
  } fd_reg_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction bus between the fetch unit (master) and the memory side (slave).
// A request stays asserted and stable until the slave returns iresp_data_ok.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = IBUS_ADDR_W,
  parameter int DATA_W = IBUS_DATA_W
);

  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_addr_ok;
  logic              iresp_data_ok;
  logic [DATA_W-1:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_addr_ok,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_addr_ok,
    output iresp_data_ok,
    output iresp_data
  );

endinterface

// File: rtl/fetch_unit_fd_pipe_reg.sv
// F/D pipeline register: flush beats load, load beats hold, and an
// unstalled cycle without a load leaves a bubble.
module fd_pipe_reg
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = IBUS_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_load,
  input  logic                   i_flush,
  input  logic                   i_stall,
  input  logic [IBUS_DATA_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]      i_pc,
  output logic                   o_valid,
  output logic [IBUS_DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0]      o_pc
);

  logic                   r_valid;
  logic [IBUS_DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0]      r_pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (!i_stall) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the ibus handshake, absorbs
// redirects and decode stalls, and feeds the F/D register to decode.
module fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] PC_RESET = fetch_unit_pkg::PC_RESET
) (
  input  logic              clk,
  input  logic              reset,
  fetch_unit_if.master      ibus,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              fd_valid,
  output logic [31:0]       fd_instr,
  output logic [ADDR_W-1:0] fd_pc
);

  import fetch_unit_pkg::*;

  fetch_state_t           r_state, w_next_state;
  logic [ADDR_W-1:0]      r_pc, w_next_pc;
  logic                   r_kill, w_next_kill;
  logic [ADDR_W-1:0]      r_kill_pc, w_next_kill_pc;
  logic [IBUS_DATA_W-1:0] r_skid_instr, w_next_skid;

  logic                   w_rdr;
  logic [ADDR_W-1:0]      w_redirect_pc;
  logic [ADDR_W-1:0]      w_target;
  logic                   w_fd_load;
  logic                   w_fd_flush;
  logic [IBUS_DATA_W-1:0] w_fd_instr;
  logic                   w_unused_addr_ok;

  assign w_redirect_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  // A redirect seen this cycle overrides one remembered from an earlier cycle.
  assign w_rdr    = redirect_valid | r_kill;
  assign w_target = redirect_valid ? w_redirect_pc : r_kill_pc;

  assign ibus.ireq_valid = (r_state == FETCH);
  assign ibus.ireq_addr  = r_pc;
  assign w_unused_addr_ok = ibus.iresp_addr_ok;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_next_pc      = r_pc;
    w_next_kill    = r_kill;
    w_next_kill_pc = r_kill_pc;
    w_next_skid    = r_skid_instr;
    w_fd_load      = 1'b0;
    w_fd_flush     = redirect_valid;
    w_fd_instr     = ibus.iresp_data;

    case (r_state)
      IDLE: begin
        w_next_state = FETCH;
        if (redirect_valid) w_next_pc = w_redirect_pc;
      end
      FETCH: begin
        if (!ibus.iresp_data_ok) begin
          // The request cannot be withdrawn; remember where to go when it lands.
          if (redirect_valid) begin
            w_next_kill    = 1'b1;
            w_next_kill_pc = w_redirect_pc;
          end
        end else if (w_rdr) begin
          w_next_pc   = w_target;
          w_next_kill = 1'b0;
          w_fd_flush  = 1'b1;
        end else if (!stall || !fd_valid) begin
          w_fd_load = 1'b1;
          w_next_pc = r_pc + ADDR_W'(4);
        end else begin
          w_next_skid  = ibus.iresp_data;
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_next_pc    = w_redirect_pc;
          w_next_state = FETCH;
        end else if (!stall) begin
          w_fd_load    = 1'b1;
          w_fd_instr   = r_skid_instr;
          w_next_pc    = r_pc + ADDR_W'(4);
          w_next_state = FETCH;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= PC_RESET;
      r_kill       <= 1'b0;
      r_kill_pc    <= '0;
      r_skid_instr <= '0;
    end else begin
      r_state      <= w_next_state;
      r_pc         <= w_next_pc;
      r_kill       <= w_next_kill;
      r_kill_pc    <= w_next_kill_pc;
      r_skid_instr <= w_next_skid;
    end
  end

  fd_pipe_reg #(.ADDR_W(ADDR_W)) u_fd_pipe_reg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_fd_load),
    .i_flush (w_fd_flush),
    .i_stall (stall),
    .i_instr (w_fd_instr),
    .i_pc    (r_pc),
    .o_valid (fd_valid),
    .o_instr (fd_instr),
    .o_pc    (fd_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run scored
// against an instruction-stream model (expected PC sequence + memory image).
module tb_fetch_unit;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        fd_valid;
  logic [31:0] fd_instr;
  logic [63:0] fd_pc;

  fetch_unit_if #(.ADDR_W(64), .DATA_W(32)) ibus ();

  fetch_unit #(.ADDR_W(64), .PC_RESET(BASE)) dut (
    .clk            (clk),
    .reset          (reset),
    .ibus           (ibus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .fd_valid       (fd_valid),
    .fd_instr       (fd_instr),
    .fd_pc          (fd_pc)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Memory-side model state.
  bit          bus_auto;
  bit          bus_busy;
  int          bus_wait;
  int          bus_min;
  int          bus_max;
  bit          fixed_en;
  logic [31:0] fixed_data;

  function automatic logic [31:0] instr_at(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  // Drives the response for the current cycle; bus_wait counts the request
  // cycles still to go before data_ok (0 = zero-wait).
  task automatic bus_drive();
    if (bus_auto) begin
      ibus.iresp_addr_ok = 1'b0;
      ibus.iresp_data_ok = 1'b0;
      if (ibus.ireq_valid) begin
        if (!bus_busy) begin
          bus_busy = 1'b1;
          bus_wait = int'($urandom_range(bus_max, bus_min));
          ibus.iresp_addr_ok = 1'b1;
        end
        if (bus_wait == 0) begin
          ibus.iresp_data_ok = 1'b1;
          ibus.iresp_data    = fixed_en ? fixed_data : instr_at(ibus.ireq_addr);
          bus_busy           = 1'b0;
        end else begin
          bus_wait--;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus_drive();
  endtask

  task automatic set_lat(input int lo, input int hi);
    bus_min = lo;
    bus_max = hi;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    stall              = 1'b0;
    ibus.iresp_addr_ok = 1'b0;
    ibus.iresp_data_ok = 1'b0;
    ibus.iresp_data    = '0;
    bus_busy           = 1'b0;
    bus_wait           = 0;
    bus_auto           = 1'b1;
    fixed_en           = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_drive();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    stall = 1'b0;
    ibus.iresp_addr_ok = 1'b0;
    ibus.iresp_data_ok = 1'b0;
    ibus.iresp_data = '0;
    #1 reset = 1'b1;
    #2;
    n_total++;
    if (ibus.ireq_valid !== 1'b0) $display("FAIL rst_ireq_valid: got %b want 0", ibus.ireq_valid);
    else n_pass++;
    n_total++;
    if (ibus.ireq_addr !== BASE) $display("FAIL rst_ireq_addr: got %h want %h", ibus.ireq_addr, BASE);
    else n_pass++;
    n_total++;
    if (fd_valid !== 1'b0) $display("FAIL rst_fd_valid: got %b want 0", fd_valid);
    else n_pass++;
    n_total++;
    if (fd_instr !== 32'h0) $display("FAIL rst_fd_instr: got %h want 0", fd_instr);
    else n_pass++;
    n_total++;
    if (fd_pc !== 64'h0) $display("FAIL rst_fd_pc: got %h want 0", fd_pc);
    else n_pass++;
  endtask

  task automatic test_zero_wait();
    do_reset();
    set_lat(0, 0);
    fixed_en   = 1'b1;
    fixed_data = 32'h0000_0013;
    n_total++;
    if (ibus.ireq_valid !== 1'b0) $display("FAIL zw_idle_req: got %b want 0", ibus.ireq_valid);
    else n_pass++;
    step();
    n_total++;
    if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== BASE)
      $display("FAIL zw_first_req: got v=%b a=%h want v=1 a=%h", ibus.ireq_valid, ibus.ireq_addr, BASE);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step();
      n_total++;
      if (fd_valid !== 1'b1 || fd_pc !== BASE + 64'(4 * k) || fd_instr !== 32'h13)
        $display("FAIL zw_fd%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=00000013",
                 k, fd_valid, fd_pc, fd_instr, BASE + 64'(4 * k));
      else n_pass++;
    end
  endtask

  task automatic test_bus_latency();
    do_reset();
    set_lat(2, 2);
    step();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) begin
        n_total++;
        if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== BASE + 64'(4 * k))
          $display("FAIL lat_req%0d_%0d: got v=%b a=%h want v=1 a=%h",
                   k, c, ibus.ireq_valid, ibus.ireq_addr, BASE + 64'(4 * k));
        else n_pass++;
        n_total++;
        if (fd_valid !== (c == 0 && k > 0))
          $display("FAIL lat_fdv%0d_%0d: got %b want %b", k, c, fd_valid, (c == 0 && k > 0));
        else n_pass++;
        if (c == 0 && k > 0) begin
          n_total++;
          if (fd_pc !== BASE + 64'(4 * (k - 1)))
            $display("FAIL lat_fdpc%0d: got %h want %h", k, fd_pc, BASE + 64'(4 * (k - 1)));
          else n_pass++;
        end
        step();
      end
    end
    n_total++;
    if (fd_valid !== 1'b1 || fd_pc !== BASE + 64'd8)
      $display("FAIL lat_last: got v=%b pc=%h want v=1 pc=%h", fd_valid, fd_pc, BASE + 64'd8);
    else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    set_lat(0, 0);
    step();
    step();
    step();
    n_total++;
    if (fd_valid !== 1'b1 || fd_pc !== BASE + 64'd4)
      $display("FAIL st_pre: got v=%b pc=%h want v=1 pc=%h", fd_valid, fd_pc, BASE + 64'd4);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      stall = 1'b1;
      step();
      n_total++;
      if (fd_valid !== 1'b1 || fd_pc !== BASE + 64'd4 || fd_instr !== instr_at(BASE + 64'd4))
        $display("FAIL st_hold%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                 i, fd_valid, fd_pc, fd_instr, BASE + 64'd4, instr_at(BASE + 64'd4));
      else n_pass++;
      n_total++;
      if (ibus.ireq_valid !== 1'b0) $display("FAIL st_noreq%0d: got %b want 0", i, ibus.ireq_valid);
      else n_pass++;
    end
    stall = 1'b0;
    step();
    n_total++;
    if (fd_valid !== 1'b1 || fd_pc !== BASE + 64'd8 || fd_instr !== instr_at(BASE + 64'd8))
      $display("FAIL st_release: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
               fd_valid, fd_pc, fd_instr, BASE + 64'd8, instr_at(BASE + 64'd8));
    else n_pass++;
    n_total++;
    if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== BASE + 64'd12)
      $display("FAIL st_nextreq: got v=%b a=%h want v=1 a=%h", ibus.ireq_valid, ibus.ireq_addr, BASE + 64'd12);
    else n_pass++;
  endtask

  task automatic test_redirect_in_flight();
    do_reset();
    set_lat(2, 2);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = BASE + 64'h100;
    step();
    redirect_valid = 1'b0;
    n_total++;
    if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== BASE || fd_valid !== 1'b0)
      $display("FAIL rif_keep: got v=%b a=%h fdv=%b want v=1 a=%h fdv=0",
               ibus.ireq_valid, ibus.ireq_addr, fd_valid, BASE);
    else n_pass++;
    step();
    step();
    n_total++;
    if (fd_valid !== 1'b0 || ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== BASE + 64'h100)
      $display("FAIL rif_target: got fdv=%b v=%b a=%h want fdv=0 v=1 a=%h",
               fd_valid, ibus.ireq_valid, ibus.ireq_addr, BASE + 64'h100);
    else n_pass++;
    step();
    step();
    step();
    n_total++;
    if (fd_valid !== 1'b1 || fd_pc !== BASE + 64'h100 || fd_instr !== instr_at(BASE + 64'h100))
      $display("FAIL rif_fd: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
               fd_valid, fd_pc, fd_instr, BASE + 64'h100, instr_at(BASE + 64'h100));
    else n_pass++;
  endtask

  task automatic test_multi_redirect();
    do_reset();
    set_lat(2, 2);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = BASE + 64'h300;
    step();
    redirect_pc    = BASE + 64'h403;
    step();
    redirect_valid = 1'b0;
    step();
    n_total++;
    if (fd_valid !== 1'b0 || ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== BASE + 64'h400)
      $display("FAIL mr_last_wins: got fdv=%b v=%b a=%h want fdv=0 v=1 a=%h",
               fd_valid, ibus.ireq_valid, ibus.ireq_addr, BASE + 64'h400);
    else n_pass++;
  endtask

  task automatic test_redirect_hold();
    do_reset();
    set_lat(0, 0);
    step();
    step();
    stall = 1'b1;
    step();
    n_total++;
    if (ibus.ireq_valid !== 1'b0 || fd_valid !== 1'b1 || fd_pc !== BASE)
      $display("FAIL rh_parked: got v=%b fdv=%b pc=%h want v=0 fdv=1 pc=%h",
               ibus.ireq_valid, fd_valid, fd_pc, BASE);
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc    = BASE + 64'h200;
    step();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    n_total++;
    if (fd_valid !== 1'b0 || ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== BASE + 64'h200)
      $display("FAIL rh_flush: got fdv=%b v=%b a=%h want fdv=0 v=1 a=%h",
               fd_valid, ibus.ireq_valid, ibus.ireq_addr, BASE + 64'h200);
    else n_pass++;
    step();
    n_total++;
    if (fd_valid !== 1'b1 || fd_pc !== BASE + 64'h200 || fd_instr !== instr_at(BASE + 64'h200))
      $display("FAIL rh_fd: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
               fd_valid, fd_pc, fd_instr, BASE + 64'h200, instr_at(BASE + 64'h200));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_lat(0, 0);
    step();
    step();
    set_lat(4, 4);
    step();
    step();
    n_total++;
    if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== BASE + 64'd8)
      $display("FAIL rm_pending: got v=%b a=%h want v=1 a=%h", ibus.ireq_valid, ibus.ireq_addr, BASE + 64'd8);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (ibus.ireq_valid !== 1'b0 || ibus.ireq_addr !== BASE || fd_valid !== 1'b0)
      $display("FAIL rm_async: got v=%b a=%h fdv=%b want v=0 a=%h fdv=0",
               ibus.ireq_valid, ibus.ireq_addr, fd_valid, BASE);
    else n_pass++;
    @(posedge clk);
    #1;
    reset              = 1'b0;
    bus_auto           = 1'b0;
    ibus.iresp_data_ok = 1'b1;
    ibus.iresp_data    = 32'hDEAD_BEEF;
    step();
    bus_auto           = 1'b1;
    bus_busy           = 1'b0;
    set_lat(0, 0);
    bus_drive();
    n_total++;
    if (fd_valid !== 1'b0 || ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== BASE)
      $display("FAIL rm_restart: got fdv=%b v=%b a=%h want fdv=0 v=1 a=%h",
               fd_valid, ibus.ireq_valid, ibus.ireq_addr, BASE);
    else n_pass++;
    step();
    n_total++;
    if (fd_valid !== 1'b1 || fd_pc !== BASE || fd_instr !== instr_at(BASE))
      $display("FAIL rm_first: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
               fd_valid, fd_pc, fd_instr, BASE, instr_at(BASE));
    else n_pass++;
  endtask

  // Model: the decoder consumes F/D whenever it is valid, unstalled and not
  // flushed by a redirect; consumed PCs must follow the program order
  // (start, +4, or the aligned redirect target) and carry memory contents.
  task automatic test_random();
    logic [63:0] exp_pc;
    logic        p_fdv, p_stall, p_rdr, p_req, p_dok;
    logic [63:0] p_fdpc, p_rpc, p_addr;
    logic [31:0] p_fdi;
    int          n_accept;
    do_reset();
    set_lat(0, 3);
    exp_pc   = BASE;
    n_accept = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      stall          = ($urandom_range(99, 0) < 30);
      redirect_valid = ($urandom_range(99, 0) < 5);
      redirect_pc    = BASE + 64'($urandom_range(4095, 0));
      p_fdv = fd_valid; p_fdpc = fd_pc; p_fdi = fd_instr;
      p_stall = stall; p_rdr = redirect_valid; p_rpc = redirect_pc;
      p_req = ibus.ireq_valid; p_addr = ibus.ireq_addr; p_dok = ibus.iresp_data_ok;
      step();
      if (p_rdr) begin
        exp_pc = {p_rpc[63:2], 2'b00};
        n_total++;
        if (fd_valid !== 1'b0) $display("FAIL rnd_flush@%0d: got fdv=%b want 0", cyc, fd_valid);
        else n_pass++;
      end else if (p_fdv && !p_stall) begin
        n_total++;
        if (p_fdpc !== exp_pc || p_fdi !== instr_at(exp_pc))
          $display("FAIL rnd_stream@%0d: got pc=%h i=%h want pc=%h i=%h",
                   cyc, p_fdpc, p_fdi, exp_pc, instr_at(exp_pc));
        else n_pass++;
        exp_pc = exp_pc + 64'd4;
        n_accept++;
      end else if (p_fdv && p_stall) begin
        n_total++;
        if (fd_valid !== 1'b1 || fd_pc !== p_fdpc || fd_instr !== p_fdi)
          $display("FAIL rnd_hold@%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                   cyc, fd_valid, fd_pc, fd_instr, p_fdpc, p_fdi);
        else n_pass++;
      end
      if (p_req && !p_dok) begin
        n_total++;
        if (ibus.ireq_valid !== 1'b1 || ibus.ireq_addr !== p_addr)
          $display("FAIL rnd_bus_stable@%0d: got v=%b a=%h want v=1 a=%h",
                   cyc, ibus.ireq_valid, ibus.ireq_addr, p_addr);
        else n_pass++;
      end
    end
    redirect_valid = 1'b0;
    stall          = 1'b0;
    n_total++;
    if (n_accept < 100) $display("FAIL rnd_progress: got %0d accepted want >= 100", n_accept);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_bus_latency();
    test_stall();
    test_redirect_in_flight();
    test_multi_redirect();
    test_redirect_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Owns the architectural PC and drives the instruction bus request/response handshake.
- Applies branch/jump redirects from execute.
- Holds the F/D pipeline register whose raw_instr and pc feed the decoder.
- Sustains one instruction per cycle on a zero-wait bus and tolerates arbitrary bus latency, decode stalls and redirects arriving mid-transaction.

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, PC value loaded on reset.
- ADDR_W, 64, width of PC and bus address.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ireq_valid  out  1  instruction bus request valid.
- ireq_addr  out  ADDR_W  instruction bus request address.
- iresp_addr_ok  in  1  bus accepted address (informational only; not used for control).
- iresp_data_ok  in  1  response data valid this cycle; completes the request.
- iresp_data  in  32  fetched instruction word.
- redirect_valid  in  1  execute requests PC change (taken branch, jal, jalr).
- redirect_pc  in  ADDR_W  redirect target.
- stall  in  1  decode cannot accept; F/D register must hold.
- fd_valid  out  1  F/D register holds a live instruction.
- fd_instr  out  32  instruction to decoder raw_instr.
- fd_pc  out  ADDR_W  PC of fd_instr, to decoder pc.

Behaviour:
- Reset values (asserted asynchronously): pc=PC_RESET, state=IDLE, fd_valid=0, fd_instr=0, fd_pc=0, kill=0, kill_pc=0, skid_instr=0. ireq_valid=0, ireq_addr=pc.
- Bus rule: once ireq_valid=1, ireq_valid and ireq_addr stay stable until the cycle iresp_data_ok=1. A request is never withdrawn, including on redirect.
- States:
  - IDLE: ireq_valid=0; next cycle goes to FETCH unconditionally.
  - FETCH: ireq_valid=1, ireq_addr=pc.
  - HOLD: ireq_valid=0; fetched instruction parked in skid_instr awaiting decode.
- Effective redirect, rdr = redirect_valid or kill. Target = redirect_pc if redirect_valid, else kill_pc; the current-cycle redirect wins.
- FETCH with data_ok=0:
  - If redirect_valid: kill<=1, kill_pc<=redirect_pc, fd_valid<=0.
  - pc is unchanged.
- FETCH with data_ok=1:
  - rdr: discard data, pc<=target, kill<=0, fd_valid<=0, stay FETCH.
  - !rdr and (stall=0 or fd_valid=0): fd_instr<=iresp_data, fd_pc<=pc, fd_valid<=1, pc<=pc+4, stay FETCH.
  - !rdr and stall=1 and fd_valid=1: skid_instr<=iresp_data, go HOLD. pc is unchanged.
- HOLD:
  - redirect_valid: drop skid, pc<=redirect_pc, fd_valid<=0, go FETCH.
  - else stall=0: fd_instr<=skid_instr, fd_pc<=pc, fd_valid<=1, pc<=pc+4, go FETCH.
  - else remain.
- Any state with stall=0 and no new F/D load: fd_valid<=0 (bubble).
- Redirect priority: redirect_valid flushes fd_valid regardless of stall.
- Latency: zero-wait bus (data_ok in the request cycle) gives fd_valid one cycle after request, back-to-back every cycle. A redirect costs at least one bubble.
- Arithmetic: pc+4 modulo 2^ADDR_W (wrap permitted, no flag). redirect_pc[1:0] is forced to 2'b00 when loaded.
- Reset mid-transaction: state returns to IDLE immediately. Any later data_ok for the abandoned request is ignored because IDLE does not sample the bus.
- Multiple redirects before data_ok: the last one wins in kill_pc.

Decomposition:
- Shared pipes package:
  - fetch_state_t enum {IDLE, FETCH, HOLD}.
  - fd_reg_t struct {valid, instr, pc}, consumed by the decode stage.
  - PC_RESET localparam.
- ibus request/response field widths come from the existing common package.
- One natural sub-module: fd_pipe_reg, the F/D register with load/flush/hold controls.

Test Plan:
- Reset then zero-wait bus (data_ok=1 every cycle, data=0x00000013): fd_pc=0x80000000, 0x80000004, 0x80000008 on consecutive cycles with fd_valid=1. ireq_valid=0 in the first post-reset cycle.
- Bus latency 3 cycles: ireq_addr held 0x80000000 for 3 cycles; fd_valid pulses once per completed fetch.
- stall=1 for 4 cycles with fd_valid=1: F/D holds 0x80000004. The next fetch parks in HOLD with ireq_valid=0. After stall drops, fd_pc=0x80000008.
- redirect_valid with redirect_pc=0x80000100 two cycles before data_ok: the returned word is discarded, fd_valid=0, and the next ireq_addr is 0x80000100.
- Redirect in HOLD combined with stall=1: skid dropped, fd_valid=0, next request at the target.
- Reset asserted while waiting for data_ok, with a late data_ok after reset release: no fd_valid, and the first request is at 0x80000000.
